// File: rtl/spi_bist_pkg.sv
// Shared definitions for the SPI BIST engine.
//   state_t    : controller FSM states
//   lfsr_taps(): maximal-length Fibonacci LFSR tap mask for widths 4..32
//                (bit k set means state bit k feeds the XOR)
package spi_bist_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StXfer,
        StGap,
        StFin
    } state_t;

    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        logic [31:0] taps;
        case (width)
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_D008;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0004_0023;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h00E1_0000;
            25:      taps = 32'h0120_0000;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0900_0000;
            29:      taps = 32'h1400_0000;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4800_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR: shifts left, XOR of the tapped bits enters at bit 0.
//   i_clk, i_reset : clock, asynchronous active-high reset (state <- seed)
//   i_load         : reload the seed
//   i_step         : advance one step
//   o_state        : current LFSR word
module lfsr_gen #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'hB8),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_step,
    output logic [WIDTH-1:0] o_state
);

    // An all-zero state would lock up, so a zero seed becomes 1.
    localparam logic [WIDTH-1:0] LP_SEED = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [WIDTH-1:0] r_state;
    logic             w_fb;

    assign w_fb    = ^(r_state & TAPS);
    assign o_state = r_state;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= LP_SEED;
        end else if (i_load) begin
            r_state <= LP_SEED;
        end else if (i_step) begin
            r_state <= {r_state[WIDTH-2:0], w_fb};
        end
    end

endmodule

// File: rtl/spi_bist_engine.sv
// SPI master built-in self test: sends NUM_WORDS LFSR words, captures the
// returned words and counts mismatches.
//   i_clk, i_reset         : clock, asynchronous active-high reset
//   i_start                : one-cycle run request (honoured only when idle)
//   i_cpol, i_cpha         : SPI mode, latched at start
//   i_miso                 : serial data in
//   o_sclk, o_mosi, o_cs_n : SPI bus
//   o_busy, o_done, o_pass : run status
//   o_err_count            : mismatched word count, saturating at 255
//   o_last_tx, o_last_rx   : most recent transmitted / received word
module spi_bist_engine
    import spi_bist_pkg::*;
#(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       NUM_WORDS = 16,
    parameter int unsigned       DIV       = 2,
    parameter logic [DATA_W-1:0] SEED      = DATA_W'('h10)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_cpol,
    input  logic              i_cpha,
    input  logic              i_miso,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic              o_cs_n,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [7:0]        o_err_count,
    output logic [DATA_W-1:0] o_last_tx,
    output logic [DATA_W-1:0] o_last_rx
);

    localparam int unsigned       CNT_W        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned       EDGE_W       = $clog2(2 * DATA_W);
    localparam logic [CNT_W-1:0]  LP_DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [EDGE_W-1:0] LP_EDGE_LAST = EDGE_W'(2 * DATA_W - 1);
    localparam logic [7:0]        LP_WORD_LAST = 8'(NUM_WORDS - 1);
    localparam logic [31:0]       LP_TAPS_ALL  = lfsr_taps(DATA_W);
    localparam logic [DATA_W-1:0] LP_TAPS      = LP_TAPS_ALL[DATA_W-1:0];

    state_t              r_state;
    state_t              w_next_state;
    logic                r_cpol;
    logic                r_cpha;
    logic                r_sclk;
    logic [CNT_W-1:0]    r_div_cnt;
    logic [EDGE_W-1:0]   r_edge_cnt;
    logic [7:0]          r_word_cnt;
    logic [DATA_W-1:0]   r_tx_shift;
    logic [DATA_W-1:0]   r_rx_shift;
    logic [7:0]          r_err_count;
    logic                r_pass;
    logic [DATA_W-1:0]   r_last_tx;
    logic [DATA_W-1:0]   r_last_rx;

    logic [DATA_W-1:0]   w_lfsr;
    logic                w_load;
    logic                w_step;
    logic                w_div_end;
    logic                w_edge_tick;
    logic                w_last_edge;
    logic                w_lead;
    logic                w_sample;
    logic                w_shift;
    logic [DATA_W-1:0]   w_rx_word;

    lfsr_gen #(
        .WIDTH (DATA_W),
        .TAPS  (LP_TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_load),
        .i_step  (w_step),
        .o_state (w_lfsr)
    );

    assign w_div_end   = (r_div_cnt == LP_DIV_LAST);
    assign w_edge_tick = (r_state == StXfer) && w_div_end;
    assign w_last_edge = (r_edge_cnt == LP_EDGE_LAST);
    assign w_lead      = ~r_edge_cnt[0];
    assign w_sample    = w_edge_tick && (r_cpha ? ~w_lead : w_lead);
    // With cpha=1 the MSB is already on mosi from SETUP, so the first
    // leading edge must not shift it away.
    assign w_shift     = w_edge_tick &&
                         (r_cpha ? (w_lead && (r_edge_cnt != '0)) : ~w_lead);
    // Includes the sample taken on the final edge (cpha=1).
    assign w_rx_word   = w_sample ? {r_rx_shift[DATA_W-2:0], i_miso} : r_rx_shift;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        o_cs_n       = 1'b1;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        o_mosi       = r_tx_shift[DATA_W-1];
        case (r_state)
            StIdle: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_next_state = StSetup;
                    w_load       = 1'b1;
                end
            end
            StSetup: begin
                o_cs_n = 1'b0;
                o_mosi = w_lfsr[DATA_W-1];
                if (w_div_end) begin
                    w_next_state = StXfer;
                end
            end
            StXfer: begin
                o_cs_n = 1'b0;
                if (w_edge_tick && w_last_edge) begin
                    w_next_state = StGap;
                    w_step       = 1'b1;
                end
            end
            StGap: begin
                if (w_div_end) begin
                    w_next_state = (r_word_cnt == LP_WORD_LAST) ? StFin : StSetup;
                end
            end
            StFin: begin
                o_done       = 1'b1;
                w_next_state = StIdle;
            end
            default: begin
                w_next_state = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_sclk      <= 1'b0;
            r_div_cnt   <= '0;
            r_edge_cnt  <= '0;
            r_word_cnt  <= '0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_err_count <= '0;
            r_pass      <= 1'b0;
            r_last_tx   <= '0;
            r_last_rx   <= '0;
        end else begin
            if (r_state == StSetup || r_state == StXfer || r_state == StGap) begin
                r_div_cnt <= w_div_end ? '0 : r_div_cnt + 1'b1;
            end else begin
                r_div_cnt <= '0;
            end

            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_cpol      <= i_cpol;
                        r_cpha      <= i_cpha;
                        r_sclk      <= i_cpol;
                        r_err_count <= '0;
                        r_pass      <= 1'b0;
                        r_word_cnt  <= '0;
                    end
                end
                StSetup: begin
                    if (w_div_end) begin
                        r_tx_shift <= w_lfsr;
                        r_edge_cnt <= '0;
                    end
                end
                StXfer: begin
                    if (w_edge_tick) begin
                        // Even number of toggles leaves sclk back at cpol.
                        r_sclk     <= ~r_sclk;
                        r_edge_cnt <= r_edge_cnt + 1'b1;
                        r_rx_shift <= w_rx_word;
                        if (w_shift) begin
                            r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                        end
                        if (w_last_edge) begin
                            r_last_tx <= w_lfsr;
                            r_last_rx <= w_rx_word;
                            if ((w_rx_word != w_lfsr) && (r_err_count != 8'hFF)) begin
                                r_err_count <= r_err_count + 8'd1;
                            end
                        end
                    end
                end
                StGap: begin
                    if (w_div_end) begin
                        if (r_word_cnt == LP_WORD_LAST) begin
                            r_pass <= (r_err_count == 8'd0);
                        end else begin
                            r_word_cnt <= r_word_cnt + 8'd1;
                        end
                    end
                end
                StFin: begin
                    r_tx_shift <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_sclk      = r_sclk;
    assign o_pass      = r_pass;
    assign o_err_count = r_err_count;
    assign o_last_tx   = r_last_tx;
    assign o_last_rx   = r_last_rx;

endmodule

// File: tb/tb_spi_bist_engine.sv
// Directed bench for spi_bist_engine (DATA_W=8, NUM_WORDS=4, DIV=2, SEED=0x10).
// LFSR words: 0x10, 0x21, 0x43, 0x86. Run length 4*18*2+1 = 145 cycles.
module tb_spi_bist_engine;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned NUM_WORDS = 4;
    localparam int unsigned DIV       = 2;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              cpol  = 1'b0;
    logic              cpha  = 1'b0;
    logic              miso;
    logic              sclk;
    logic              mosi;
    logic              cs_n;
    logic              busy;
    logic              done;
    logic              pass;
    logic [7:0]        err_count;
    logic [DATA_W-1:0] last_tx;
    logic [DATA_W-1:0] last_rx;

    // 0: loopback, 1: tied low, 2: loopback inverted during word index 2
    int miso_mode = 0;
    int word_idx  = 0;
    int checks    = 0;
    int errors    = 0;

    assign miso = (miso_mode == 0) ? mosi :
                  (miso_mode == 1) ? 1'b0 : (mosi ^ (word_idx == 2));

    always #5 clk = ~clk;

    spi_bist_engine #(
        .DATA_W    (DATA_W),
        .NUM_WORDS (NUM_WORDS),
        .DIV       (DIV),
        .SEED      (8'h10)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_cpol      (cpol),
        .i_cpha      (cpha),
        .i_miso      (miso),
        .o_sclk      (sclk),
        .o_mosi      (mosi),
        .o_cs_n      (cs_n),
        .o_busy      (busy),
        .o_done      (done),
        .o_pass      (pass),
        .o_err_count (err_count),
        .o_last_tx   (last_tx),
        .o_last_rx   (last_rx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string      name;
        logic       cpol;
        logic       cpha;
        int         mmode;
        bit         dbl_start;
        int         exp_len;
        logic [7:0] exp_err;
        logic       exp_pass;
        logic [7:0] exp_tx;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input vec_t v);
        int         cyc;
        int         ndone;
        int         done_cyc;
        int         mosi_bad;
        int         sclk_bad;
        logic       pass_at_done;
        logic       prev_sclk;
        logic       prev_mosi;
        logic       prev_cs;
        logic [7:0] first_tx;
        bit         got_first;
        bit         is_sample;
        ndone        = 0;
        done_cyc     = 0;
        mosi_bad     = 0;
        sclk_bad     = 0;
        pass_at_done = 1'bx;
        first_tx     = 8'hxx;
        got_first    = 1'b0;
        @(negedge clk);
        cpol      = v.cpol;
        cpha      = v.cpha;
        miso_mode = v.mmode;
        word_idx  = 0;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        cyc       = 1;
        prev_sclk = sclk;
        prev_mosi = mosi;
        prev_cs   = cs_n;
        while (cyc < 400 && (done_cyc == 0 || cyc < done_cyc + 5)) begin
            if (done === 1'b1) begin
                ndone++;
                if (done_cyc == 0) begin
                    done_cyc     = cyc;
                    pass_at_done = pass;
                end
            end
            if (busy && cs_n && (sclk !== cpol)) sclk_bad++;
            if (sclk !== prev_sclk) begin
                is_sample = cpha ? (sclk == cpol) : (sclk != cpol);
                if (is_sample && (mosi !== prev_mosi)) mosi_bad++;
            end
            if (cs_n && !prev_cs) begin
                word_idx++;
                if (!got_first) first_tx = last_tx;
                got_first = 1'b1;
            end
            prev_sclk = sclk;
            prev_mosi = mosi;
            prev_cs   = cs_n;
            start     = (v.dbl_start && cyc == 20);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({v.name, " run_len"}, done_cyc, v.exp_len);
        check({v.name, " done_pulses"}, ndone, 1);
        check({v.name, " pass_at_done"}, pass_at_done, v.exp_pass);
        check({v.name, " pass_held"}, pass, v.exp_pass);
        check({v.name, " err_count"}, err_count, v.exp_err);
        check({v.name, " last_tx"}, last_tx, v.exp_tx);
        check({v.name, " last_rx"}, last_rx, v.exp_rx);
        check({v.name, " first_tx"}, first_tx, 8'h10);
        check({v.name, " busy_after"}, busy, 1'b0);
        check({v.name, " mosi_stable_at_sample"}, mosi_bad, 0);
        check({v.name, " sclk_idle_cpol"}, sclk_bad, 0);
    endtask

    initial begin
        int rises;
        int ndone;
        logic prev_cs;

        vecs[0] = '{"loop_m0",  1'b0, 1'b0, 0, 1'b0, 145, 8'd0, 1'b1, 8'h86, 8'h86};
        vecs[1] = '{"zero_m0",  1'b0, 1'b0, 1, 1'b0, 145, 8'd4, 1'b0, 8'h86, 8'h00};
        vecs[2] = '{"inv2_m0",  1'b0, 1'b0, 2, 1'b0, 145, 8'd1, 1'b0, 8'h86, 8'h86};
        vecs[3] = '{"loop_m1",  1'b0, 1'b1, 0, 1'b0, 145, 8'd0, 1'b1, 8'h86, 8'h86};
        vecs[4] = '{"loop_m2",  1'b1, 1'b0, 0, 1'b0, 145, 8'd0, 1'b1, 8'h86, 8'h86};
        vecs[5] = '{"loop_m3",  1'b1, 1'b1, 0, 1'b0, 145, 8'd0, 1'b1, 8'h86, 8'h86};
        vecs[6] = '{"dbl_start", 1'b0, 1'b0, 0, 1'b1, 145, 8'd0, 1'b1, 8'h86, 8'h86};

        // Reset state while reset is held.
        #12;
        check("rst cs_n", cs_n, 1'b1);
        check("rst sclk", sclk, 1'b0);
        check("rst mosi", mosi, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst pass", pass, 1'b0);
        check("rst err_count", err_count, 8'd0);
        check("rst last_tx", last_tx, 8'h00);
        check("rst last_rx", last_rx, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst busy", busy, 1'b0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // Abort during word index 2.
        @(negedge clk);
        cpol      = 1'b0;
        cpha      = 1'b0;
        miso_mode = 0;
        start     = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        rises   = 0;
        prev_cs = cs_n;
        for (int c = 0; c < 300 && rises < 2; c++) begin
            @(negedge clk);
            if (cs_n && !prev_cs) rises++;
            prev_cs = cs_n;
        end
        check("abort reached word2", rises, 2);
        repeat (10) @(negedge clk);
        check("abort cs_n before", cs_n, 1'b0);
        check("abort busy before", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("abort cs_n async", cs_n, 1'b1);
        check("abort busy async", busy, 1'b0);
        check("abort sclk", sclk, 1'b0);
        check("abort err_count", err_count, 8'd0);
        check("abort last_tx", last_tx, 8'h00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("abort no_done", ndone, 0);
        check("abort idle cs_n", cs_n, 1'b1);

        vecs[0].name = "after_abort";
        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
